// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared widths, state type and grant encoding for the SRAM arbiter
package sram_pkg;

   localparam int ADDR_W_DEF = 20;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      WR_HOLD = 3'd2,
      RD      = 3'd3,
      RD_CAP  = 3'd4
   } sram_state_t;

   // Encoding of the last_grant register.
   localparam logic GRANT_WR = 1'b0;
   localparam logic GRANT_RD = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick between write and read requesters
module rr_arb2
   import sram_pkg::*;
(
   input  logic wr_req,
   input  logic rd_req,
   input  logic last_grant,
   output logic gnt_wr,
   output logic gnt_rd
);

   always_comb begin
      gnt_wr = 1'b0;
      gnt_rd = 1'b0;
      if (wr_req && rd_req) begin
         // Contention: whoever was not served last goes next.
         gnt_wr = (last_grant == GRANT_RD);
         gnt_rd = (last_grant == GRANT_WR);
      end else begin
         gnt_wr = wr_req;
         gnt_rd = rd_req;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - arbitrates one write and one read requester onto an async SRAM
module sram_arbiter
   import sram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              en,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   inout  wire  [DATA_W-1:0] SRAM_DQ,
   output logic              SRAM_CE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_WE_N,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N
);

   sram_state_t       state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              wr_ack_q, wr_ack_d;
   logic              rd_valid_q, rd_valid_d;
   logic              busy_q, busy_d;
   logic              ce_n_q, ce_n_d;
   logic              oe_n_q, oe_n_d;
   logic              we_n_q, we_n_d;
   logic              dq_oe_q, dq_oe_d;
   logic              gnt_wr, gnt_rd;

   rr_arb2 u_rr_arb2 (
      .wr_req     (wr_req),
      .rd_req     (rd_req),
      .last_grant (last_grant_q),
      .gnt_wr     (gnt_wr),
      .gnt_rd     (gnt_rd)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      case (state_q)
         IDLE: begin
            if (en && gnt_wr) begin
               state_d      = WR;
               last_grant_d = GRANT_WR;
               addr_d       = wr_addr;
               wdata_d      = wr_data;
            end else if (en && gnt_rd) begin
               state_d      = RD;
               last_grant_d = GRANT_RD;
               addr_d       = rd_addr;
            end
         end
         WR:      state_d = WR_HOLD;
         WR_HOLD: state_d = IDLE;
         RD: begin
            // OE_N has been low for a full cycle, so the SRAM output is settled here.
            state_d = RD_CAP;
            rdata_d = SRAM_DQ;
         end
         RD_CAP:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Pins are decoded from the next state so every output comes straight from a flop.
      wr_ack_d   = (state_d == WR_HOLD);
      rd_valid_d = (state_d == RD_CAP);
      busy_d     = (state_d != IDLE);
      ce_n_d     = (state_d == IDLE);
      we_n_d     = (state_d != WR);
      oe_n_d     = !((state_d == RD) || (state_d == RD_CAP));
      dq_oe_d    = (state_d == WR) || (state_d == WR_HOLD);
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_RD;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         wr_ack_q     <= 1'b0;
         rd_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         ce_n_q       <= 1'b1;
         oe_n_q       <= 1'b1;
         we_n_q       <= 1'b1;
         dq_oe_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         wr_ack_q     <= wr_ack_d;
         rd_valid_q   <= rd_valid_d;
         busy_q       <= busy_d;
         ce_n_q       <= ce_n_d;
         oe_n_q       <= oe_n_d;
         we_n_q       <= we_n_d;
         dq_oe_q      <= dq_oe_d;
      end
   end

   assign SRAM_DQ   = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
   assign SRAM_ADDR = addr_q;
   assign SRAM_CE_N = ce_n_q;
   assign SRAM_OE_N = oe_n_q;
   assign SRAM_WE_N = we_n_q;
   assign SRAM_UB_N = ce_n_q;
   assign SRAM_LB_N = ce_n_q;
   assign wr_ack    = wr_ack_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter with a behavioural async SRAM
module tb_sram_arbiter;
   import sram_pkg::*;

   localparam int AW = 20;
   localparam int DW = 16;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b0;
   logic          en = 1'b0;
   logic          wr_req = 1'b0;
   logic          rd_req = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_ack, rd_valid, busy;
   logic [DW-1:0] rd_data;
   logic [AW-1:0] sram_addr;
   wire  [DW-1:0] sram_dq;
   logic          ce_n, oe_n, we_n, ub_n, lb_n;

   int errors = 0;
   int checks = 0;
   int bus_viol = 0;

   typedef struct {
      logic          is_rd;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;
   exp_t exp_q[$];

   logic [DW-1:0] mem [0:255];
   logic          model_oe;

   always #5 i_clk = ~i_clk;

   sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .en        (en),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ack    (wr_ack),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .busy      (busy),
      .SRAM_ADDR (sram_addr),
      .SRAM_DQ   (sram_dq),
      .SRAM_CE_N (ce_n),
      .SRAM_OE_N (oe_n),
      .SRAM_WE_N (we_n),
      .SRAM_UB_N (ub_n),
      .SRAM_LB_N (lb_n)
   );

   assign model_oe = !ce_n && !oe_n && we_n;
   assign sram_dq  = model_oe ? mem[sram_addr[7:0]] : {DW{1'bz}};

   always @(posedge i_clk) begin
      if (!ce_n && !we_n) mem[sram_addr[7:0]] <= sram_dq;
   end

   // Scoreboard: every ack/valid pops one expected access.
   initial begin
      exp_t e;
      logic [DW-1:0] got;
      forever begin
         @(negedge i_clk);
         if (wr_ack || rd_valid) begin
            checks++;
            if (wr_ack && rd_valid) begin
               errors++;
               $display("FAIL ack_collision wr_ack=%0b rd_valid=%0b required one-hot", wr_ack, rd_valid);
            end else if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event wr_ack=%0b rd_valid=%0b required no event", wr_ack, rd_valid);
            end else begin
               e = exp_q.pop_front();
               got = rd_valid ? rd_data : sram_dq;
               if (rd_valid !== e.is_rd) begin
                  errors++;
                  $display("FAIL grant_order got_rd=%0b required_rd=%0b", rd_valid, e.is_rd);
               end
               checks++;
               if (sram_addr !== e.addr) begin
                  errors++;
                  $display("FAIL access_addr got=%h required=%h", sram_addr, e.addr);
               end
               checks++;
               if (got !== e.data) begin
                  errors++;
                  $display("FAIL access_data got=%h required=%h", got, e.data);
               end
            end
         end
      end
   end

   // Bus-safety watch across the whole run.
   initial begin
      forever begin
         @(negedge i_clk);
         if (!oe_n && !we_n) bus_viol++;
         if (ub_n !== ce_n || lb_n !== ce_n) bus_viol++;
         if (!oe_n && ce_n) bus_viol++;
      end
   end

   task automatic do_access(input logic is_rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int lat, output int we_cnt, output int oe_cnt, output int dq_cnt);
      exp_t e;
      lat = 0; we_cnt = 0; oe_cnt = 0; dq_cnt = 0;
      e.is_rd = is_rd; e.addr = a; e.data = d;
      exp_q.push_back(e);
      if (is_rd) begin
         rd_addr = a; rd_req = 1'b1;
      end else begin
         wr_addr = a; wr_data = d; wr_req = 1'b1;
      end
      for (int i = 1; i <= 10; i++) begin
         @(negedge i_clk);
         if (!we_n) we_cnt++;
         if (!oe_n) oe_cnt++;
         if (!ce_n && oe_n && sram_dq === d) dq_cnt++;
         if ((is_rd && rd_valid) || (!is_rd && wr_ack)) lat = i;
         @(posedge i_clk);
         #1;
         if (lat != 0) break;
      end
      if (is_rd) rd_req = 1'b0;
      else wr_req = 1'b0;
      checks++;
      if (lat == 0) begin
         errors++;
         $display("FAIL access_timeout addr=%h got=no_event required=event", a);
         void'(exp_q.pop_back());
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b0; en = 1'b0;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b required=0", busy); end
      checks++;
      if ({wr_ack, rd_valid} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b required=00", {wr_ack, rd_valid}); end
      checks++;
      if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got=%h required=0", rd_data); end
      checks++;
      if (sram_addr !== '0) begin errors++; $display("FAIL reset_addr got=%h required=0", sram_addr); end
      checks++;
      if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 5'h1f) begin
         errors++; $display("FAIL reset_ctl got=%b required=11111", {ce_n, oe_n, we_n, ub_n, lb_n});
      end
      @(posedge i_clk);
      #1;
      i_rst = 1'b1; en = 1'b1;
   endtask

   task automatic test_write_only();
      int lat, we_cnt, oe_cnt, dq_cnt;
      do_access(1'b0, 20'h00010, 16'hA5A5, lat, we_cnt, oe_cnt, dq_cnt);
      checks++;
      if (lat != 3) begin errors++; $display("FAIL wr_latency got=%0d required=3", lat); end
      checks++;
      if (we_cnt != 1) begin errors++; $display("FAIL wr_we_cycles got=%0d required=1", we_cnt); end
      checks++;
      if (dq_cnt != 2) begin errors++; $display("FAIL wr_dq_cycles got=%0d required=2", dq_cnt); end
      checks++;
      if (oe_cnt != 0) begin errors++; $display("FAIL wr_oe_cycles got=%0d required=0", oe_cnt); end
   endtask

   task automatic test_read_only();
      int lat, we_cnt, oe_cnt, dq_cnt;
      do_access(1'b1, 20'h00010, 16'hA5A5, lat, we_cnt, oe_cnt, dq_cnt);
      checks++;
      if (lat != 3) begin errors++; $display("FAIL rd_latency got=%0d required=3", lat); end
      checks++;
      if (oe_cnt != 2) begin errors++; $display("FAIL rd_oe_cycles got=%0d required=2", oe_cnt); end
      checks++;
      if (we_cnt != 0 || dq_cnt != 0) begin
         errors++; $display("FAIL rd_dq_driven got_we=%0d got_dq=%0d required=0", we_cnt, dq_cnt);
      end
   endtask

   task automatic test_simultaneous();
      exp_t e;
      int t[4];
      int n = 0;
      int extra = 0;
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      wr_addr = 20'h00020; wr_data = 16'h1234; rd_addr = 20'h00010;
      wr_req = 1'b1; rd_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         e.is_rd = (k % 2 == 1);
         e.addr  = e.is_rd ? 20'h00010 : 20'h00020;
         e.data  = e.is_rd ? 16'hA5A5 : 16'h1234;
         exp_q.push_back(e);
      end
      @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge i_clk);
         if ((wr_ack || rd_valid) && n < 4) begin t[n] = i; n++; end
         @(posedge i_clk);
         #1;
         if (n == 4) break;
      end
      wr_req = 1'b0; rd_req = 1'b0;
      checks++;
      if (n != 4) begin errors++; $display("FAIL sim_event_count got=%0d required=4", n); end
      for (int k = 1; k < 4; k++) begin
         checks++;
         if (k < n && t[k] - t[k-1] != 3) begin
            errors++; $display("FAIL sim_interval_%0d got=%0d required=3", k, t[k] - t[k-1]);
         end
      end
      repeat (6) begin
         @(negedge i_clk);
         if (busy || wr_ack || rd_valid) extra++;
      end
      checks++;
      if (extra != 0) begin errors++; $display("FAIL sim_no_reissue got=%0d required=0", extra); end
   endtask

   task automatic test_enable();
      exp_t e;
      int viol = 0;
      int got = 0;
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      @(posedge i_clk);
      #1;
      i_rst = 1'b1; en = 1'b0;
      wr_addr = 20'h00040; wr_data = 16'h0F0F; rd_addr = 20'h00010;
      wr_req = 1'b1; rd_req = 1'b1;
      repeat (6) begin
         @(negedge i_clk);
         if (busy || !ce_n || !oe_n || !we_n || wr_ack || rd_valid) viol++;
      end
      checks++;
      if (viol != 0) begin errors++; $display("FAIL en_low_idle got=%0d required=0", viol); end
      @(posedge i_clk);
      #1;
      en = 1'b1;
      e.is_rd = 1'b0; e.addr = 20'h00040; e.data = 16'h0F0F;
      exp_q.push_back(e);
      @(posedge i_clk);
      #1;
      en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge i_clk);
         if (wr_ack) got = 1;
         @(posedge i_clk);
         #1;
         if (got != 0) break;
      end
      wr_req = 1'b0;
      checks++;
      if (got != 1) begin errors++; $display("FAIL en_drop_completes got=%0d required=1", got); end
      viol = 0;
      repeat (6) begin
         @(negedge i_clk);
         if (busy || rd_valid) viol++;
      end
      checks++;
      if (viol != 0) begin errors++; $display("FAIL en_low_no_grant got=%0d required=0", viol); end
      rd_req = 1'b0; en = 1'b1;
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int lat, we_cnt, oe_cnt, dq_cnt;
      int found = 0;
      wr_addr = 20'h00030; wr_data = 16'hBEEF; wr_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         if (!we_n) begin found = 1; break; end
      end
      checks++;
      if (found != 1) begin errors++; $display("FAIL rst_mid_reach_wr got=%0d required=1", found); end
      i_rst = 1'b0;
      #1;
      checks++;
      if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 5'h1f || busy !== 1'b0 || sram_addr !== '0) begin
         errors++;
         $display("FAIL rst_mid_pins got_ctl=%b busy=%b addr=%h required=11111/0/0",
                  {ce_n, oe_n, we_n, ub_n, lb_n}, busy, sram_addr);
      end
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      do_access(1'b0, 20'h00030, 16'hBEEF, lat, we_cnt, oe_cnt, dq_cnt);
      checks++;
      if (lat != 3) begin errors++; $display("FAIL rst_mid_reissue got=%0d required=3", lat); end
   endtask

   task automatic test_back_to_back();
      int lat, we_cnt, oe_cnt, dq_cnt;
      int bad = 0;
      logic [DW-1:0] tbl [4];
      tbl[0] = 16'h1111; tbl[1] = 16'h2222; tbl[2] = 16'h3333; tbl[3] = 16'h4444;
      for (int i = 0; i < 4; i++) begin
         do_access(1'b0, AW'(i), tbl[i], lat, we_cnt, oe_cnt, dq_cnt);
         if (lat != 3) bad++;
      end
      for (int i = 0; i < 4; i++) begin
         do_access(1'b1, AW'(i), tbl[i], lat, we_cnt, oe_cnt, dq_cnt);
         if (lat != 3 || we_cnt != 0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL b2b_timing got=%0d required=0", bad); end
      checks++;
      if (bus_viol != 0) begin errors++; $display("FAIL bus_safety got=%0d required=0", bus_viol); end
   endtask

   initial begin
      test_reset();
      test_write_only();
      test_read_only();
      test_simultaneous();
      test_enable();
      test_reset_mid();
      test_back_to_back();
      repeat (4) @(posedge i_clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
